// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem fetch,
// two-entry {instr, pc} queue toward decode, branch redirect flush.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inflight_pc;
   logic        r_drop;
   logic [1:0]  r_cnt;
   logic [31:0] r_head_instr;
   logic [31:0] r_head_pc;
   logic [31:0] r_skid_instr;
   logic [31:0] r_skid_pc;

   logic [1:0]  w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic        w_drop_nxt;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic [31:0] w_redir_pc;

   assign w_redir_pc     = {redirect_pc[31:2], 2'b00};
   assign imem_req_valid = (r_state == S_REQ) && (r_cnt < 2'd2);
   assign imem_req_addr  = r_pc;
   assign w_accept       = imem_req_valid && imem_req_ready;
   assign w_push         = (r_state == S_WAIT) && imem_rsp_valid
                           && !r_drop && !redirect_valid;
   assign id_valid       = (r_cnt != 2'd0);
   assign w_pop          = id_valid && id_ready;
   assign id_instr       = r_head_instr;
   assign id_pc          = r_head_pc;

   // Next state, next pc and drop flag; redirect overrides the pc.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_drop_nxt  = r_drop;
      unique case (1'b1)
         (r_state == S_IDLE): begin
            w_state_nxt = S_REQ;
         end
         (r_state == S_REQ): begin
            if (w_accept) begin
               w_state_nxt = S_WAIT;
               w_pc_nxt    = r_pc + 32'd4;
               w_drop_nxt  = 1'b0;
            end
         end
         (r_state == S_WAIT): begin
            if (imem_rsp_valid) begin
               w_state_nxt = S_REQ;
               w_drop_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (redirect_valid) begin
         w_pc_nxt = w_redir_pc;
         if (w_accept)
            w_drop_nxt = 1'b1;
         if ((r_state == S_WAIT) && !imem_rsp_valid)
            w_drop_nxt = 1'b1;
      end
   end

   // Fetch control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   // Remember the address of the request awaiting its response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_inflight_pc <= 32'd0;
      else if (w_accept)
         r_inflight_pc <= r_pc;
   end

   // Two-entry head/skid queue; redirect empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= 2'd0;
         r_head_instr <= 32'd0;
         r_head_pc    <= 32'd0;
         r_skid_instr <= 32'd0;
         r_skid_pc    <= 32'd0;
      end else if (redirect_valid) begin
         r_cnt <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) begin
                  r_head_instr <= imem_rsp_data;
                  r_head_pc    <= r_inflight_pc;
               end else begin
                  r_skid_instr <= imem_rsp_data;
                  r_skid_pc    <= r_inflight_pc;
               end
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_head_instr <= r_skid_instr;
               r_head_pc    <= r_skid_pc;
               r_cnt        <= r_cnt - 2'd1;
            end
            2'b11: begin
               if (r_cnt == 2'd1) begin
                  r_head_instr <= imem_rsp_data;
                  r_head_pc    <= r_inflight_pc;
               end else begin
                  r_head_instr <= r_skid_instr;
                  r_head_pc    <= r_skid_pc;
                  r_skid_instr <= imem_rsp_data;
                  r_skid_pc    <= r_inflight_pc;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic,
// checked against a fetch-stream scoreboard with epoch tagging.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'd0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_pc;
   int          epoch = 0;
   bit          m_busy = 1'b0;
   int          m_wait = 0;
   logic [31:0] m_addr = 32'd0;
   int          m_tag = 0;
   int          mdly = 0;
   int          n_pop = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      chk("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("id_pc", id_pc, exp_q[0][31:0]);
         chk("id_instr", id_instr, exp_q[0][63:32]);
      end
   endtask

   // One clock: drive at negedge, model the edge, check at next negedge.
   task automatic step(input bit rdy, input bit redir,
                       input logic [31:0] rpc, input bit mrdy,
                       input bit rgo);
      bit acc;
      bit pop;
      bit rsp;
      int tag0;
      rsp            = m_busy && (m_wait == 0) && rgo;
      id_ready       = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_req_ready = mrdy;
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? mem(m_addr) : $urandom;
      #1;
      acc = imem_req_valid && imem_req_ready;
      pop = id_valid && id_ready;
      if (imem_req_valid)
         chk("req_gate", 32'(m_busy || (exp_q.size() >= 2)), 32'd0);
      if (acc)
         chk("req_addr", imem_req_addr, exp_pc);
      @(posedge clk);
      tag0 = epoch;
      if (m_busy) begin
         if (rsp) m_busy = 1'b0;
         else if (m_wait > 0) m_wait--;
      end
      if (redir) begin
         exp_q.delete();
         epoch++;
      end else begin
         if (pop && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_pop++;
         end
         if (rsp && (m_tag == tag0))
            exp_q.push_back({mem(m_addr), m_addr});
      end
      if (acc) begin
         m_busy = 1'b1;
         m_addr = exp_pc;
         m_tag  = tag0;
         m_wait = mdly;
         exp_pc = exp_pc + 32'd4;
      end
      if (redir)
         exp_pc = {rpc[31:2], 2'b00};
      @(negedge clk);
      check_out();
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      exp_q.delete();
      exp_pc = RESET_PC;
      m_busy = 1'b0;
      m_wait = 0;
      mdly   = 0;
      n_pop  = 0;
      epoch++;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_id_instr", id_instr, 32'd0);
      chk("rst_id_pc", id_pc, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      @(negedge clk);

      // T1: basic zero-wait fetch stream
      do_reset();
      chk("t1_idle_req", 32'(imem_req_valid), 32'd0);
      step(1, 0, 32'd0, 1, 1);
      chk("t1_first_req", 32'(imem_req_valid), 32'd1);
      chk("t1_first_addr", imem_req_addr, RESET_PC);
      for (int i = 0; i < 10; i++) step(1, 0, 32'd0, 1, 1);
      chk("t1_delivered", 32'(n_pop >= 4), 32'd1);

      // T2: back-pressure fills the queue, then drains in order
      do_reset();
      for (int i = 0; i < 12; i++) step(0, 0, 32'd0, 1, 1);
      chk("t2_full_valid", 32'(id_valid), 32'd1);
      chk("t2_full_pc", id_pc, 32'h0);
      chk("t2_blocked", 32'(imem_req_valid), 32'd0);
      step(1, 0, 32'd0, 1, 1);
      chk("t2_second_pc", id_pc, 32'h4);
      for (int i = 0; i < 10; i++) step(1, 0, 32'd0, 1, 1);

      // T3: redirect while waiting for the pc 8 response
      do_reset();
      for (int i = 0; i < 30 && exp_pc != 32'hC; i++)
         step(1, 0, 32'd0, 1, 1);
      chk("t3_in_wait", 32'(imem_req_valid), 32'd0);
      step(1, 1, 32'h100, 1, 0);
      step(1, 0, 32'd0, 1, 1);
      chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t3_req_addr", imem_req_addr, 32'h100);
      for (int i = 0; i < 10 && !id_valid; i++)
         step(0, 0, 32'd0, 1, 1);
      chk("t3_id_valid", 32'(id_valid), 32'd1);
      chk("t3_id_pc", id_pc, 32'h100);

      // T4: redirect in the same cycle pc 0x10 is accepted
      do_reset();
      for (int i = 0; i < 40 && !(imem_req_valid && exp_pc == 32'h10); i++)
         step(1, 0, 32'd0, 1, 1);
      step(1, 1, 32'h41, 1, 1);
      step(1, 0, 32'd0, 1, 1);
      chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t4_req_addr", imem_req_addr, 32'h40);
      for (int i = 0; i < 8; i++) step(1, 0, 32'd0, 1, 1);

      // T5: redirect with a full queue and decode stalled
      do_reset();
      for (int i = 0; i < 12; i++) step(0, 0, 32'd0, 1, 1);
      step(0, 1, 32'h200, 1, 1);
      chk("t5_flushed", 32'(id_valid), 32'd0);
      for (int i = 0; i < 10; i++) step(1, 0, 32'd0, 1, 1);

      // T6: asynchronous reset mid-WAIT with one queued entry
      do_reset();
      for (int i = 0; i < 30 && exp_pc != 32'h8; i++)
         step(0, 0, 32'd0, 1, 1);
      chk("t6_one_entry", 32'(id_valid), 32'd1);
      #2;
      do_reset();
      step(1, 0, 32'd0, 1, 1);
      chk("t6_restart_req", 32'(imem_req_valid), 32'd1);
      chk("t6_restart_addr", imem_req_addr, RESET_PC);

      // Random traffic, including redirects near the address wrap
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         mdly = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0)
            rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else
            rpc = $urandom;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc,
              $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      end
      chk("rand_progress", 32'(n_pop > 50), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that sits directly upstream of instruction decode and immediate generation.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request with a valid-only response.
- Buffers up to two fetched instructions and presents {instr, pc} to decode over a valid/ready handshake.
- Accepts a redirect from the branch unit (taken bne, target = pc + B-immediate), which flushes all wrong-path work.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  fetch address (bits [1:0] always 0)
imem_rsp_valid  input  1  response valid; one response per accepted request, in order, at least 1 cycle after acceptance
imem_rsp_data  input  32  fetched instruction word
id_valid  output  1  decode-side entry valid
id_ready  input  1  decode accepts entry
id_instr  output  32  instruction word for decode/immgen
id_pc  output  32  address of id_instr
redirect_valid  input  1  redirect fetch (pulse, 1 cycle)
redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 0

Behaviour:
Reset and clocking:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0: state=IDLE, pc=RESET_PC, queue count=0, drop flag=0.
- While rst_n=0: imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0.

State machine:
- States are IDLE, REQ and WAIT. IDLE->REQ unconditionally on the first edge after reset release.
- REQ: imem_req_valid = (count<2), using the registered count with no same-cycle pop bypass. imem_req_addr = pc.
  - On imem_req_valid & imem_req_ready: inflight_pc<=pc, pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0), go to WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid: if drop=0, push {imem_rsp_data, inflight_pc}. Then clear drop and go to REQ.
- At most one outstanding request at any time.

Queue:
- Two entries, head and skid. id_valid = (count!=0); id_instr/id_pc come from the head.
- Pop on id_valid & id_ready; skid moves to head.
- Push and pop in the same cycle keep count unchanged and preserve order.
- A push when count=1 with no pop goes to skid.
- A push at count=2 cannot occur, because requests are blocked at count=2.
- While id_valid=1 and id_ready=0, id_instr/id_pc must be stable.

Redirect (highest priority, evaluated each cycle):
- pc <= {redirect_pc[31:2], 2'b00}. count<=0, so id_valid falls the next cycle; a same-cycle decode pop is a don't-care.
- Any response arriving in the redirect cycle is discarded.
- Redirect in WAIT without a response that cycle: set drop=1 and stay in WAIT; the next response is discarded and then the FSM goes to REQ.
- Redirect in REQ where the request is also accepted that cycle: that request is wrong-path. Go to WAIT with drop=1, and pc takes the redirect target, not pc+4.
- Redirect in REQ with no acceptance: stay in REQ; the next request uses the new pc.
- Redirect in IDLE: only pc is updated.
- Redirect in the same cycle as a response that ends WAIT: the response is discarded and the FSM goes to REQ with drop=0.

Timing:
- Request accepted at cycle N, response at N+1 gives id_valid at N+2 (registered).
- Peak throughput is one instruction per 2 cycles.
- Reset asserted mid-WAIT clears everything immediately; responses arriving after reset release for pre-reset requests are the memory model's responsibility and not tracked.

Test Plan:
1. Reset, RESET_PC=0, zero-wait memory, id_ready=1 -> first imem_req_addr=0 one cycle after release; id_pc sequence 0,4,8,C with matching id_instr; id_valid first high 2 cycles after first acceptance.
2. Hold id_ready=0 -> queue fills with pc 0,4; imem_req_valid stays 0 at count=2; raise id_ready -> entries 0,4 delivered in order, then fetch resumes at 8.
3. Redirect to 0x100 while in WAIT for pc 8 -> response for 8 never appears on id_*; next request addr=0x100, id_pc=0x100.
4. Redirect to 0x41 in the same cycle imem_req_ready accepts pc 0x10 -> 0x10 response dropped; next request addr=0x40.
5. Redirect with count=2 and id_ready=0 -> id_valid=0 the following cycle; no stale entry is ever delivered.
6. Assert rst_n=0 mid-WAIT with count=1 -> id_valid and imem_req_valid drop immediately (asynchronous); after release, fetch restarts at RESET_PC.
